// File: rtl/lzc_norm_iter.sv
// Iterative mantissa normaliser: one 4-bit leading-zero decode per SCAN cycle.
// Define LZC_NORM_UFLOW_EN to add the out_uflow exponent-underflow flag.
module lzc_norm_iter #(
    parameter  int WIDTH = 32,
    parameter  int EXPW  = 10,
    localparam int LZW   = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mant,
    input  logic [EXPW-1:0]  in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXPW-1:0]  out_exp,
    output logic [LZW-1:0]   out_lzc,
`ifdef LZC_NORM_UFLOW_EN
    output logic             out_uflow,
`endif
    output logic             out_zero
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    // Compare width wide enough for both the unsigned exponent and the count
    localparam int CW = (EXPW + 1 > LZW) ? EXPW + 1 : LZW;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_work;
    logic [EXPW-1:0]  r_exp;
    logic [LZW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_out_mant;
    logic [EXPW-1:0]  r_out_exp;
    logic [LZW-1:0]   r_out_lzc;
    logic             r_out_zero;

    logic [3:0]       w_nib;
    logic             w_nib_v;
    logic [1:0]       w_nib_c;
    logic             w_last;
    logic [WIDTH-1:0] w_work_sh;
    logic [LZW-1:0]   w_cnt_nx;
    logic [EXPW-1:0]  w_exp_nx;

    assign w_nib     = r_work[WIDTH-1:WIDTH-4];
    assign w_nib_v   = |w_nib;
    assign w_nib_c   = w_nib[3] ? 2'd0 : w_nib[2] ? 2'd1 : w_nib[1] ? 2'd2 : 2'd3;
    assign w_last    = (32'(r_cnt) + 32'd4) == 32'(WIDTH);
    assign w_work_sh = r_work << w_nib_c;
    assign w_cnt_nx  = r_cnt + LZW'(w_nib_c);
    assign w_exp_nx  = r_exp - EXPW'(w_nib_c);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    // NOTE: default assignment first, so no path through the case can infer a latch.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (in_valid)          w_state_nx = SCAN;
            SCAN:    if (w_nib_v || w_last) w_state_nx = DONE;
            DONE:    if (out_ready)         w_state_nx = IDLE;
            default:                        w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

`ifdef LZC_NORM_UFLOW_EN
    logic [EXPW-1:0] r_in_exp;
    logic            r_out_uflow;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_in_exp    <= '0;
            r_out_uflow <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_in_exp <= in_exp;
        end else if (r_state == SCAN) begin
            if (w_nib_v)     r_out_uflow <= CW'({1'b0, r_in_exp}) < CW'(w_cnt_nx);
            else if (w_last) r_out_uflow <= 1'b0;
        end
    end
    assign out_uflow = r_out_uflow;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_work     <= '0;
            r_exp      <= '0;
            r_cnt      <= '0;
            r_out_mant <= '0;
            r_out_exp  <= '0;
            r_out_lzc  <= '0;
            r_out_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_work <= in_mant;
                    r_exp  <= in_exp;
                    r_cnt  <= '0;
                end
                SCAN: begin
                    if (w_nib_v) begin
                        r_work     <= w_work_sh;
                        r_cnt      <= w_cnt_nx;
                        r_exp      <= w_exp_nx;
                        r_out_mant <= w_work_sh;
                        r_out_exp  <= w_exp_nx;
                        r_out_lzc  <= w_cnt_nx;
                        r_out_zero <= 1'b0;
                    end else if (!w_last) begin
                        r_work <= r_work << 4;
                        r_cnt  <= r_cnt + LZW'(4);
                        r_exp  <= r_exp - EXPW'(4);
                    end else begin
                        // All nibbles empty: report the zero result
                        r_out_mant <= '0;
                        r_out_exp  <= '0;
                        r_out_lzc  <= LZW'(WIDTH);
                        r_out_zero <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_mant = r_out_mant;
    assign out_exp  = r_out_exp;
    assign out_lzc  = r_out_lzc;
    assign out_zero = r_out_zero;

endmodule

// File: tb/tb_lzc_norm_iter.sv
// Scoreboard bench for lzc_norm_iter: driver pushes expectations, monitor pops on out_valid.
module tb_lzc_norm_iter;

    localparam int WIDTH = 32;
    localparam int EXPW  = 10;
    localparam int LZW   = $clog2(WIDTH + 1);

    typedef struct {
        logic [WIDTH-1:0] mant;
        logic [EXPW-1:0]  e;
        logic [LZW-1:0]   lzc;
        logic             z;
        logic             uf;
        int               lat;
        longint           t0;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_mant = '0;
    logic [EXPW-1:0]  in_exp = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_mant;
    logic [EXPW-1:0]  out_exp;
    logic [LZW-1:0]   out_lzc;
    logic             out_zero;
`ifdef LZC_NORM_UFLOW_EN
    logic             out_uflow;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic seen = 1'b0;

    lzc_norm_iter #(.WIDTH(WIDTH), .EXPW(EXPW)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mant  (in_mant),
        .in_exp   (in_exp),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mant (out_mant),
        .out_exp  (out_exp),
        .out_lzc  (out_lzc),
`ifdef LZC_NORM_UFLOW_EN
        .out_uflow(out_uflow),
`endif
        .out_zero (out_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compare each newly presented result against the scoreboard head
    always @(negedge clock) begin
        if (!out_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            exp_t x;
            seen = 1'b1;
            if (sb.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                x = sb.pop_front();
                check("out_mant", 64'(out_mant), 64'(x.mant));
                check("out_exp",  64'(out_exp),  64'(x.e));
                check("out_lzc",  64'(out_lzc),  64'(x.lzc));
                check("out_zero", 64'(out_zero), 64'(x.z));
`ifdef LZC_NORM_UFLOW_EN
                check("out_uflow", 64'(out_uflow), 64'(x.uf));
`endif
                check("latency", 64'(($time - x.t0 - 5) / 10), 64'(x.lat));
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] m, input logic [EXPW-1:0] e,
                        input logic [WIDTH-1:0] xm, input logic [EXPW-1:0] xe,
                        input logic [LZW-1:0] xl, input logic xz, input logic xu,
                        input int lat);
        exp_t x;
        int   n = 0;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
        in_valid = 1'b1;
        in_mant  = m;
        in_exp   = e;
        @(posedge clock);
        x.mant = xm; x.e = xe; x.lzc = xl; x.z = xz; x.uf = xu; x.lat = lat; x.t0 = $time;
        sb.push_back(x);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #12;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_mant",  64'(out_mant),  64'd0);
        check("rst_out_lzc",   64'(out_lzc),   64'd0);
        check("rst_out_zero",  64'(out_zero),  64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Directed vectors: mant, exp -> mant, exp, lzc, zero, uflow, latency
        send(32'h8000_0000, 10'd100, 32'h8000_0000, 10'd100,  6'd0,  1'b0, 1'b0, 1);
        send(32'h0001_2345, 10'd50,  32'h91A2_8000, 10'd35,   6'd15, 1'b0, 1'b0, 4);
        send(32'h0000_0000, 10'd77,  32'h0000_0000, 10'd0,    6'd32, 1'b1, 1'b0, 8);
        send(32'h0000_0001, 10'd10,  32'h8000_0000, 10'd1003, 6'd31, 1'b0, 1'b1, 8);
        send(32'h0F00_0000, 10'd3,   32'hF000_0000, 10'd1023, 6'd4,  1'b0, 1'b1, 2);
        send(32'h0040_0000, 10'd200, 32'h8000_0000, 10'd191,  6'd9,  1'b0, 1'b0, 3);
        wait_drain();

        // Backpressure: result must hold in DONE and new operands be ignored
        out_ready = 1'b0;
        send(32'h2000_0001, 10'd5, 32'h8000_0004, 10'd3, 6'd2, 1'b0, 1'b0, 1);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clock);
                n++;
            end
        end
        check("bp_out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_mant  = 32'h0000_00FF;
            in_exp   = 10'd9;
            @(negedge clock);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready",   64'(in_ready),  64'd0);
            check("bp_hold_mant",  64'(out_mant),  64'h8000_0004);
            check("bp_hold_exp",   64'(out_exp),   64'd3);
            check("bp_hold_lzc",   64'(out_lzc),   64'd2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready),  64'd1);
        send(32'h8000_0000, 10'd100, 32'h8000_0000, 10'd100, 6'd0, 1'b0, 1'b0, 1);
        wait_drain();

        // Reset during the third SCAN cycle of the 0x1 operand
        @(negedge clock);
        in_valid = 1'b1;
        in_mant  = 32'h0000_0001;
        in_exp   = 10'd10;
        @(posedge clock);
        #1 in_valid = 1'b0;
        #20;
        check("mid_scan_busy", 64'(in_ready), 64'd0);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready",  64'(in_ready),  64'd1);
        check("mid_rst_out_mant",  64'(out_mant),  64'd0);
        check("mid_rst_out_exp",   64'(out_exp),   64'd0);
        check("mid_rst_out_lzc",   64'(out_lzc),   64'd0);
        @(negedge clock);
        reset = 1'b1;
        send(32'h0001_2345, 10'd50, 32'h91A2_8000, 10'd35, 6'd15, 1'b0, 1'b0, 4);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lzc_norm_iter.md
Name:
lzc_norm_iter

Overview:
- Iterative mantissa normaliser that consumes leading-zero counts nibble by nibble.
- Per cycle: one 4-bit leading-zero decode (count + valid) on the top nibble of a working register; shift left accordingly; decrement exponent.
- Sits downstream of the FPU's 4-bit LZC primitive, between the add/sub datapath and rounding.
- Multi-cycle block with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, mantissa width in bits; must be a multiple of 4 and at least 8.
- EXPW, 10, exponent width; two's-complement arithmetic, modulo 2^EXPW.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand.
- in_mant  in  WIDTH  unnormalised mantissa.
- in_exp  in  EXPW  exponent of in_mant.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_mant  out  WIDTH  normalised mantissa (MSB=1 unless zero).
- out_exp  out  EXPW  in_exp minus out_lzc, modulo 2^EXPW; 0 when zero.
- out_lzc  out  LZW=$clog2(WIDTH+1)  total leading zeros.
- out_zero  out  1  in_mant was all zeros.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE; in_ready=1.
  - out_valid=0; out_mant=0; out_exp=0; out_lzc=0; out_zero=0.
  - Internal working registers cleared.
- States: IDLE, SCAN, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE:
  - On in_valid&&in_ready: load work=in_mant, exp=in_exp, cnt=0; go to SCAN.
  - Otherwise hold.
- SCAN: decode the top nibble of work, n=work[WIDTH-1:WIDTH-4]; nibble valid v=|n; nibble count c = leading zeros of n (0..3).
  - v=1: work<<=c, cnt+=c, exp-=c; go to DONE.
  - v=0 and cnt+4<WIDTH: work<<=4, cnt+=4, exp-=4; stay in SCAN.
  - v=0 and cnt+4==WIDTH: zero case. Go to DONE with out_zero=1, out_mant=0, out_lzc=WIDTH, out_exp=0.
- DONE:
  - Outputs are registered and held stable while out_ready=0.
  - On out_ready=1: go to IDLE, deassert out_valid.
  - in_valid is ignored outside IDLE.
- Latency, from the accepting edge to the edge after which out_valid=1:
  - nonzero input: k = floor(lz/4)+1 cycles;
  - zero input: WIDTH/4 cycles;
  - WIDTH=32: 1..8 cycles.
- Throughput: one operand per k+2 cycles minimum (IDLE, SCAN×k, DONE).
- Exponent arithmetic wraps silently modulo 2^EXPW; no saturation.
- Reset asserted mid-SCAN or in DONE: the in-flight operation is dropped, all outputs are at reset values immediately, and the first operand after release is processed normally.
- out_mant, out_exp, out_lzc, out_zero change only on the SCAN→DONE transition and on reset.

Optional Feature:
- Macro: LZC_NORM_UFLOW_EN.
- Defined:
  - Extra port out_uflow, out, 1 bit.
  - Set on entry to DONE when in_exp, treated as unsigned, is less than the final cnt (EXPW+1-bit compare).
  - Forced to 0 for zero inputs; reset value 0; held with the other outputs.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- 1. in_mant=0x80000000, in_exp=100 -> out_mant=0x80000000, out_exp=100, out_lzc=0, out_zero=0; out_valid 1 cycle after acceptance.
- 2. in_mant=0x00012345, in_exp=50 -> out_mant=0x91A28000, out_exp=35, out_lzc=15; latency 4.
- 3. in_mant=0x00000000, in_exp=77 -> out_zero=1, out_mant=0, out_lzc=32, out_exp=0; latency 8; out_uflow=0 if enabled.
- 4. in_mant=0x00000001, in_exp=10 -> out_mant=0x80000000, out_lzc=31, out_exp=1003 (wrap); latency 8; out_uflow=1 with LZC_NORM_UFLOW_EN.
- 5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle, next operand accepted.
- 6. Reset pulse during 3rd SCAN cycle of case 4 -> out_valid=0 and in_ready=1 immediately; after release, case 2 gives exact case-2 results.
